// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states, funct3
// encodings, byte-lane mask and load extension.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // size: 00 byte, 01 halfword, 1x word (funct3[1:0])
   function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] ofs);
      case (size)
         2'b00:   byte_mask = 4'b0001 << ofs;
         2'b01:   byte_mask = ofs[1] ? 4'b1100 : 4'b0011;
         default: byte_mask = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] ofs);
      logic [31:0] sh;
      sh = word >> {ofs, 3'b000};
      case (f3)
         F3_B:    load_extend = {{24{sh[7]}}, sh[7:0]};
         F3_BU:   load_extend = {24'd0, sh[7:0]};
         F3_H:    load_extend = {{16{sh[15]}}, sh[15:0]};
         F3_HU:   load_extend = {16'd0, sh[15:0]};
         default: load_extend = word;
      endcase
   endfunction

endpackage

// File: rtl/dmem_if.sv
// Core-to-memory data port: request fields from the core, result and handshake back.
interface dmem_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
);
   logic              rd;
   logic              wr;
   logic [ADDR_W-1:0] addr;
   logic [2:0]        funct3;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] rd_data;
   logic              ready;
   logic              err;
   logic              busy;

   modport master (output rd, wr, addr, funct3, wr_data, input rd_data, ready, err, busy);
   modport slave  (input rd, wr, addr, funct3, wr_data, output rd_data, ready, err, busy);
endinterface

// File: rtl/dmem_array.sv
// Word-organised RAM with per-byte write enables and combinational read.
module dmem_array #(
   parameter int IDX_W = 7
) (
   input  logic             clk,
   input  logic             we,
   input  logic [3:0]       be,
   input  logic [IDX_W-1:0] idx,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem [2**IDX_W];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: latches a load/store request, waits WAIT_CYCLES, then
// performs the sized access and returns a one-cycle ready (with err on rejection).
//
// state | meaning
// IDLE  | waiting for rd|wr; request fields latched on the sampling edge
// WAIT  | counting down programmed wait states
// ACK   | access performed on entry; ready/err are registered out of this state
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 9,
   parameter int WAIT_CYCLES = 1
) (
   input  logic  clk,
   input  logic  reset,
   dmem_if.slave bus
);

   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   state_t            state, state_nxt;
   logic [3:0]        cnt, cnt_nxt;
   logic              sample, enter_ack;
   logic              lat_rd, lat_wr, lat_err;
   logic [ADDR_W-1:0] lat_addr;
   logic [2:0]        lat_f3;
   logic [DATA_W-1:0] lat_wd;
   logic              req_err;
   logic              idle;
   logic              cur_rd, cur_wr, cur_err;
   logic [ADDR_W-1:0] cur_addr;
   logic [2:0]        cur_f3;
   logic [DATA_W-1:0] cur_wd;
   logic [1:0]        ofs;
   logic [3:0]        be;
   logic              ram_we;
   logic [DATA_W-1:0] ram_wdata, ram_rdata;
   logic [DATA_W-1:0] rd_data_q;
   logic              ready_q, err_q;

   always_comb begin
      req_err = bus.rd & bus.wr;
      case (bus.funct3)
         F3_B:    ;
         F3_H:    if (bus.addr[0]) req_err = 1'b1;
         F3_W:    if (bus.addr[1:0] != 2'b00) req_err = 1'b1;
         F3_BU:   if (bus.wr) req_err = 1'b1;
         F3_HU:   if (bus.wr || bus.addr[0]) req_err = 1'b1;
         default: req_err = 1'b1;
      endcase
   end

   // With WAIT_CYCLES=0 the access happens on the sampling edge, so the live
   // request is used while idle and the latched copy afterwards.
   assign idle     = (state == IDLE);
   assign cur_rd   = idle ? bus.rd      : lat_rd;
   assign cur_wr   = idle ? bus.wr      : lat_wr;
   assign cur_err  = idle ? req_err     : lat_err;
   assign cur_addr = idle ? bus.addr    : lat_addr;
   assign cur_f3   = idle ? bus.funct3  : lat_f3;
   assign cur_wd   = idle ? bus.wr_data : lat_wd;

   assign ofs       = cur_addr[1:0];
   assign be        = byte_mask(cur_f3[1:0], ofs);
   assign ram_we    = enter_ack & cur_wr & ~cur_err;
   assign ram_wdata = cur_wd << {ofs, 3'b000};

   dmem_array #(.IDX_W(ADDR_W - 2)) u_array (
      .clk   (clk),
      .we    (ram_we),
      .be    (be),
      .idx   (cur_addr[ADDR_W-1:2]),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      sample    = 1'b0;
      enter_ack = 1'b0;
      case (state)
         IDLE: begin
            if (bus.rd || bus.wr) begin
               sample  = 1'b1;
               cnt_nxt = CNT_INIT;
               if (WAIT_CYCLES == 0) begin
                  state_nxt = ACK;
                  enter_ack = 1'b1;
               end else begin
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               state_nxt = ACK;
               enter_ack = 1'b1;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         lat_rd    <= 1'b0;
         lat_wr    <= 1'b0;
         lat_err   <= 1'b0;
         lat_addr  <= '0;
         lat_f3    <= 3'd0;
         lat_wd    <= '0;
         rd_data_q <= '0;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (sample) begin
            lat_rd   <= bus.rd;
            lat_wr   <= bus.wr;
            lat_err  <= req_err;
            lat_addr <= bus.addr;
            lat_f3   <= bus.funct3;
            lat_wd   <= bus.wr_data;
         end
         // A rejected access with rd set (including rd&wr) reports a zero result.
         if (enter_ack && cur_rd) begin
            rd_data_q <= cur_err ? '0 : load_extend(ram_rdata, cur_f3, ofs);
         end
         ready_q <= (state == ACK);
         err_q   <= (state == ACK) && lat_err;
      end
   end

   assign bus.rd_data = rd_data_q;
   assign bus.ready   = ready_q;
   assign bus.err     = err_q;
   assign bus.busy    = (state != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT_CYCLES 1, 0, 3) checked each cycle
// against a timeline/byte-array model, plus hand-computed directed expectations.
module tb_dmem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]        rst_s, rd_s, wr_s;
   logic [2:0][8:0]   addr_s;
   logic [2:0][2:0]   f3_s;
   logic [2:0][31:0]  wd_s;
   logic [2:0]        ready_o, err_o, busy_o;
   logic [2:0][31:0]  rdd_o;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      dmem_if #(.ADDR_W(9), .DATA_W(32)) bus ();
      assign bus.rd      = rd_s[g];
      assign bus.wr      = wr_s[g];
      assign bus.addr    = addr_s[g];
      assign bus.funct3  = f3_s[g];
      assign bus.wr_data = wd_s[g];
      assign ready_o[g]  = bus.ready;
      assign err_o[g]    = bus.err;
      assign busy_o[g]   = bus.busy;
      assign rdd_o[g]    = bus.rd_data;
      dmem_responder #(.DATA_W(32), .ADDR_W(9),
                       .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 0 : 3))) u_dut (
         .clk   (clk),
         .reset (rst_s[g]),
         .bus   (bus.slave)
      );
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s inst%0d t=%0t: got %h expected %h", nm, k, $time, got, want);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int wc(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
   endfunction

   function automatic int m_size(input logic [2:0] f);
      case (f)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         3'b010:         return 4;
         default:        return 0;
      endcase
   endfunction

   function automatic bit m_reject(input bit r, input bit w, input logic [8:0] a, input logic [2:0] f);
      int nb;
      nb = m_size(f);
      if (r && w) return 1'b1;
      if (nb == 0) return 1'b1;
      if (w && f[2]) return 1'b1;
      if ((int'(a) % nb) != 0) return 1'b1;
      return 1'b0;
   endfunction

   logic [31:0] mm [3][128];

   function automatic logic [7:0] m_byte(input int k, input int a);
      logic [31:0] w;
      w = mm[k][a / 4];
      return w[8*(a % 4) +: 8];
   endfunction

   function automatic logic [31:0] m_load(input int k, input logic [8:0] a, input logic [2:0] f);
      int nb;
      logic [31:0] v;
      nb = m_size(f);
      v  = 32'd0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = m_byte(k, int'(a) + i);
      if ((f == 3'b000 || f == 3'b001) && v[8*nb-1]) begin
         for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
      end
      return v;
   endfunction

   task automatic m_store(input int k, input logic [8:0] a, input logic [2:0] f, input logic [31:0] d);
      int nb, ab;
      nb = m_size(f);
      for (int i = 0; i < nb; i++) begin
         ab = int'(a) + i;
         mm[k][ab / 4][8*(ab % 4) +: 8] = d[8*i +: 8];
      end
   endtask

   bit          act [3];
   int          n_s [3];
   int          idle_from [3];
   bit          m_rd [3];
   bit          m_wr [3];
   logic [8:0]  m_addr [3];
   logic [2:0]  m_f3 [3];
   logic [31:0] m_wd [3];
   logic [31:0] exp_rd [3];
   bit          exp_ready [3];
   bit          exp_err [3];
   bit          exp_busy [3];
   int          ecount = 0;

   // Request sampled at edge N: access takes effect at N+W, ready in the cycle
   // after N+W+1, busy after edges N..N+W, next sample no earlier than N+W+2.
   always @(posedge clk) begin
      ecount++;
      for (int k = 0; k < 3; k++) begin
         if (!rst_s[k]) begin
            act[k] = 0; idle_from[k] = 0; exp_rd[k] = 32'd0;
            exp_ready[k] = 0; exp_err[k] = 0; exp_busy[k] = 0;
         end else begin
            exp_ready[k] = 0;
            exp_err[k]   = 0;
            if (act[k] && ecount == n_s[k] + wc(k) + 1) begin
               exp_ready[k] = 1;
               exp_err[k]   = m_reject(m_rd[k], m_wr[k], m_addr[k], m_f3[k]);
               act[k]       = 0;
               idle_from[k] = ecount + 1;
            end else if (!act[k] && ecount >= idle_from[k] && (rd_s[k] || wr_s[k])) begin
               act[k] = 1; n_s[k] = ecount;
               m_rd[k] = rd_s[k]; m_wr[k] = wr_s[k];
               m_addr[k] = addr_s[k]; m_f3[k] = f3_s[k]; m_wd[k] = wd_s[k];
            end
            if (act[k] && ecount == n_s[k] + wc(k)) begin
               if (m_rd[k])
                  exp_rd[k] = m_reject(m_rd[k], m_wr[k], m_addr[k], m_f3[k]) ? 32'd0
                              : m_load(k, m_addr[k], m_f3[k]);
               else if (!m_reject(m_rd[k], m_wr[k], m_addr[k], m_f3[k]))
                  m_store(k, m_addr[k], m_f3[k], m_wd[k]);
            end
            exp_busy[k] = act[k];
         end
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         chk("ready", k, {31'd0, ready_o[k]}, {31'd0, rst_s[k] & exp_ready[k]});
         chk("err",   k, {31'd0, err_o[k]},   {31'd0, rst_s[k] & exp_err[k]});
         chk("busy",  k, {31'd0, busy_o[k]},  {31'd0, rst_s[k] & exp_busy[k]});
         chk("rd_data", k, rdd_o[k], rst_s[k] ? exp_rd[k] : 32'd0);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic do_acc(input int k, input bit r, input bit w, input logic [8:0] a,
                         input logic [2:0] f, input logic [31:0] d,
                         output logic [31:0] rdat, output bit e, output int lat);
      @(posedge clk); #1;
      rd_s[k] = r; wr_s[k] = w; addr_s[k] = a; f3_s[k] = f; wd_s[k] = d;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!ready_o[k] && lat < 30);
      chk("ready_seen", k, {31'd0, ready_o[k]}, 32'd1);
      rdat = rdd_o[k];
      e    = err_o[k];
      rd_s[k] = 1'b0;
      wr_s[k] = 1'b0;
   endtask

   initial begin
      logic [31:0] r;
      bit e;
      int lat, gap;
      rst_s = '0; rd_s = '0; wr_s = '0; addr_s = '0; f3_s = '0; wd_s = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ready", 0, {31'd0, ready_o[0]}, 32'd0);
      chk("reset_busy",  2, {31'd0, busy_o[2]},  32'd0);
      @(posedge clk); #1;
      rst_s = '1;

      // WAIT_CYCLES=1 instance
      do_acc(0, 0, 1, 9'h010, 3'b010, 32'hDEADBEEF, r, e, lat);
      chk("sw_err", 0, {31'd0, e}, 32'd0);
      chk("sw_latency", 0, lat, 32'd4);
      do_acc(0, 1, 0, 9'h010, 3'b010, 32'd0, r, e, lat);
      chk("lw_data", 0, r, 32'hDEADBEEF);
      do_acc(0, 0, 1, 9'h020, 3'b010, 32'h00000000, r, e, lat);
      do_acc(0, 0, 1, 9'h022, 3'b000, 32'h000000F0, r, e, lat);
      do_acc(0, 1, 0, 9'h020, 3'b010, 32'd0, r, e, lat);
      chk("sb_word", 0, r, 32'h00F00000);
      do_acc(0, 1, 0, 9'h022, 3'b000, 32'd0, r, e, lat);
      chk("lb", 0, r, 32'hFFFFFFF0);
      do_acc(0, 1, 0, 9'h022, 3'b100, 32'd0, r, e, lat);
      chk("lbu", 0, r, 32'h000000F0);
      do_acc(0, 0, 1, 9'h020, 3'b001, 32'h00008001, r, e, lat);
      do_acc(0, 1, 0, 9'h020, 3'b001, 32'd0, r, e, lat);
      chk("lh", 0, r, 32'hFFFF8001);
      do_acc(0, 1, 0, 9'h020, 3'b101, 32'd0, r, e, lat);
      chk("lhu", 0, r, 32'h00008001);
      do_acc(0, 1, 0, 9'h013, 3'b010, 32'd0, r, e, lat);
      chk("lw_misal_err", 0, {31'd0, e}, 32'd1);
      chk("lw_misal_data", 0, r, 32'd0);
      do_acc(0, 0, 1, 9'h021, 3'b001, 32'h0000ABCD, r, e, lat);
      chk("sh_misal_err", 0, {31'd0, e}, 32'd1);
      do_acc(0, 1, 1, 9'h020, 3'b010, 32'h12345678, r, e, lat);
      chk("conflict_err", 0, {31'd0, e}, 32'd1);
      do_acc(0, 1, 0, 9'h020, 3'b011, 32'd0, r, e, lat);
      chk("f3_011_err", 0, {31'd0, e}, 32'd1);
      do_acc(0, 0, 1, 9'h020, 3'b100, 32'h000000FF, r, e, lat);
      chk("sbu_err", 0, {31'd0, e}, 32'd1);
      do_acc(0, 1, 0, 9'h020, 3'b010, 32'd0, r, e, lat);
      chk("word_untouched", 0, r, 32'h00F08001);
      chk("ok_err", 0, {31'd0, e}, 32'd0);

      // WAIT_CYCLES=0 instance: back-to-back with rd held high
      do_acc(1, 0, 1, 9'h004, 3'b010, 32'h0A0A0A0A, r, e, lat);
      chk("w0_latency", 1, lat, 32'd3);
      do_acc(1, 0, 1, 9'h008, 3'b010, 32'h0B0B0B0B, r, e, lat);
      @(posedge clk); #1;
      rd_s[1] = 1'b1; wr_s[1] = 1'b0; addr_s[1] = 9'h004; f3_s[1] = 3'b010;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!ready_o[1] && lat < 30);
      chk("b2b_first_ready", 1, {31'd0, ready_o[1]}, 32'd1);
      chk("b2b_first_data", 1, rdd_o[1], 32'h0A0A0A0A);
      addr_s[1] = 9'h008;
      gap = 0;
      do begin @(negedge clk); gap++; end while (!ready_o[1] && gap < 30);
      chk("b2b_second_ready", 1, {31'd0, ready_o[1]}, 32'd1);
      chk("b2b_second_data", 1, rdd_o[1], 32'h0B0B0B0B);
      chk("b2b_gap", 1, gap, 32'd2);
      rd_s[1] = 1'b0;

      // WAIT_CYCLES=3 instance: latching during WAIT, then reset mid-WAIT
      do_acc(2, 0, 1, 9'h040, 3'b010, 32'h11111111, r, e, lat);
      chk("w3_latency", 2, lat, 32'd6);
      do_acc(2, 0, 1, 9'h044, 3'b010, 32'h22222222, r, e, lat);
      @(posedge clk); #1;
      rd_s[2] = 1'b1; addr_s[2] = 9'h040; f3_s[2] = 3'b010;
      @(negedge clk); @(negedge clk);
      addr_s[2] = 9'h044;
      lat = 2;
      while (!ready_o[2] && lat < 30) begin @(negedge clk); lat++; end
      chk("latch_ready", 2, {31'd0, ready_o[2]}, 32'd1);
      chk("latch_data", 2, rdd_o[2], 32'h11111111);
      rd_s[2] = 1'b0;
      do_acc(2, 1, 0, 9'h044, 3'b010, 32'd0, r, e, lat);
      chk("pre_reset_data", 2, r, 32'h22222222);
      @(posedge clk); #1;
      wr_s[2] = 1'b1; addr_s[2] = 9'h040; f3_s[2] = 3'b010; wd_s[2] = 32'h33333333;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("wait_busy", 2, {31'd0, busy_o[2]}, 32'd1);
      rst_s[2] = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 2, {31'd0, ready_o[2]}, 32'd0);
      chk("rst_err",   2, {31'd0, err_o[2]},   32'd0);
      chk("rst_busy",  2, {31'd0, busy_o[2]},  32'd0);
      chk("rst_rd_data", 2, rdd_o[2], 32'd0);
      wr_s[2] = 1'b0;
      @(posedge clk); #1;
      rst_s[2] = 1'b1;
      do_acc(2, 1, 0, 9'h040, 3'b010, 32'd0, r, e, lat);
      chk("aborted_store", 2, r, 32'h11111111);

      repeat (3) @(posedge clk);
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory port (wr, rd, addr, wr_data, rd_data).
- Serves loads and stores from an internal word-organised RAM using a request/ready handshake with programmable wait states.
- Performs byte/halfword/word sizing and load sign/zero extension from funct3.
- Flags misaligned, conflicting or unsupported accesses.

Parameters:
- DATA_W, 32, data word width; fixed at 32 for byte-lane logic.
- ADDR_W, 9, byte-address width; RAM holds 2**(ADDR_W-2) words.
- WAIT_CYCLES, 1, extra wait cycles between request sampling and ready (0..15).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- rd  input  1  load request; held until ready.
- wr  input  1  store request; held until ready.
- addr  input  ADDR_W  byte address.
- funct3  input  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- wr_data  input  DATA_W  store data; the low bytes are used for SB/SH.
- rd_data  output  DATA_W  load result, extended to 32 bits.
- ready  output  1  one-cycle completion pulse.
- err  output  1  asserted with ready when the access was rejected.
- busy  output  1  high while in WAIT or ACK.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; ready=0, err=0, busy=0, rd_data=0; wait counter=0. RAM contents are not cleared. Reset asserted mid-WAIT aborts the access, and a pending store is not written.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - If rd|wr is high at a rising edge, latch addr, funct3, wr_data, rd, wr.
  - Classify the access:
    - err if rd&wr;
    - err if funct3 is not in the supported set (and not 100/101 on a store);
    - err if misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Next state: WAIT if WAIT_CYCLES>0, else ACK. Load counter with WAIT_CYCLES-1.
- WAIT:
  - Counter decrements each cycle; at 0 go to ACK.
  - Input changes during WAIT are ignored, because the fields were latched in IDLE.
- Transition into ACK, on the same edge:
  - Valid store: write the byte lanes selected by addr[1:0] and size. SB writes 1 lane, SH writes lanes {1,0} or {3,2}, SW writes all 4.
  - Valid load: rd_data gets the selected byte/halfword/word. Sign-extended for LB/LH; zero-extended for LBU/LHU.
  - Errored load: rd_data=0.
  - Any store: rd_data is left unchanged.
  - Errored access: RAM is untouched.
- ACK: ready=1 for exactly one cycle; err valid in that cycle. Next state is IDLE unconditionally.
- After ACK:
  - ready returns to 0; rd_data holds its value until the next load completes.
  - If rd/wr is still high in IDLE, it is a new request. Back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
- Latency: with request sampled at edge N, ready is high in the cycle following edge N+WAIT_CYCLES+1.
- busy=1 in WAIT and ACK, 0 in IDLE.
- Word index = addr[ADDR_W-1:2]. Every address is in range; there is no wrap logic.

Decomposition:
- Package dmem_pkg holds:
  - state enum {IDLE, WAIT, ACK};
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - a function computing the byte-enable mask from size and addr[1:0];
  - a load-extend function.
- Sub-module dmem_array: synchronous word RAM with 4-bit byte-enable write and combinational read. It is shared with any future instruction-memory responder.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles mid-WAIT -> ready=0, err=0, busy=0, rd_data=0. A store pending at reset is absent on a later read of the same address.
- Word round-trip, WAIT_CYCLES=1: SW addr=0x010 data=0xDEADBEEF; ready pulses 3 cycles after sampling with err=0. LW addr=0x010 -> rd_data=0xDEADBEEF.
- Sub-word stores and extension: start from SW 0x020=0x00000000.
  - SB 0x022 data=0x000000F0 -> LW gives 0x00F00000.
  - LB 0x022 -> 0xFFFFFFF0; LBU 0x022 -> 0x000000F0.
  - SH 0x020 data=0x8001 -> LH 0x020=0xFFFF8001, LHU=0x00008001.
- Misalignment: LW 0x013 -> ready with err=1, rd_data=0. SH 0x021 -> err=1, and LW 0x020 is unchanged.
- Conflict and unsupported access:
  - rd=wr=1 -> err=1 with no RAM change.
  - funct3=011 load -> err=1.
  - funct3=100 store -> err=1.
- Back-to-back and latching, WAIT_CYCLES=0:
  - rd held high across two accesses to 0x004/0x008 (addr changed after the first ready) -> two ready pulses 2 cycles apart with correct data.
  - addr changed during WAIT with WAIT_CYCLES=3 -> the originally latched address is served.
